// File: rtl/fir_seq_pkg.sv
// Shared types and width helpers for the time-multiplexed FIR tap sequencer.
package fir_seq_pkg;

    localparam int unsigned DEF_DATA_W  = 24;
    localparam int unsigned DEF_COEF_W  = 12;
    localparam int unsigned DEF_NTAPS   = 16;
    localparam int unsigned DEF_MUL_LAT = 3;

    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    function automatic int unsigned acc_w(input int unsigned dw, input int unsigned cw,
                                          input int unsigned n);
        return dw + cw + 32'($clog2(n));
    endfunction

    localparam int unsigned DEF_ADDR_W = addr_w(DEF_NTAPS);
    localparam int unsigned DEF_ACC_W  = acc_w(DEF_DATA_W, DEF_COEF_W, DEF_NTAPS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/fir_seq_if.sv
// Sample stream, coefficient write port and status of the FIR tap sequencer.
interface fir_seq_if
    import fir_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned COEF_W = DEF_COEF_W,
    parameter int unsigned AW     = DEF_ADDR_W
);
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     coef_drop;
    logic                     m_valid;
    logic                     m_ready;
    logic signed [DATA_W-1:0] m_data;
    logic                     busy;

    modport master (
        output s_valid, s_data, coef_we, coef_addr, coef_wdata, m_ready,
        input  s_ready, coef_drop, m_valid, m_data, busy
    );

    modport slave (
        input  s_valid, s_data, coef_we, coef_addr, coef_wdata, m_ready,
        output s_ready, coef_drop, m_valid, m_data, busy
    );
endinterface

// File: rtl/fir_seq_mul_pipe.sv
// Pipelined signed DATA_W x COEF_W multiplier, MUL_LAT cycles from inputs to product.
module fir_seq_mul_pipe
    import fir_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned COEF_W  = DEF_COEF_W,
    parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ce,
    input  logic signed [DATA_W-1:0]        a,
    input  logic signed [COEF_W-1:0]        b,
    output logic signed [DATA_W+COEF_W-1:0] p
);
    localparam int unsigned PW = DATA_W + COEF_W;
    localparam int unsigned PD = MUL_LAT - 1;

    logic signed [DATA_W-1:0] a_q;
    logic signed [COEF_W-1:0] b_q;
    logic signed [PW-1:0]     p_q [PD];

    // Operand registers carry no reset; validity is tracked outside by the token pipe.
    always_ff @(posedge clk) begin
        if (ce) begin
            a_q <= a;
            b_q <= b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(PD); i++) p_q[i] <= '0;
        end else if (ce) begin
            p_q[0] <= PW'(a_q) * PW'(b_q);
            for (int i = 1; i < int'(PD); i++) p_q[i] <= p_q[i-1];
        end
    end

    assign p = p_q[PD-1];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Shares one pipelined multiplier across all FIR taps and returns one scaled sample per input.
// FIR_SEQ_ROUND_SAT_EN selects round-half-up plus saturation instead of truncate-and-wrap.
module fir_tap_sequencer
    import fir_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned COEF_W  = DEF_COEF_W,
    parameter int unsigned NTAPS   = DEF_NTAPS,
    parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
    input  logic     clk,
    input  logic     reset,
    fir_seq_if.slave bus
);
    localparam int unsigned AW    = addr_w(NTAPS);
    localparam int unsigned ACC_W = acc_w(DATA_W, COEF_W, NTAPS);
    localparam int unsigned PW    = DATA_W + COEF_W;
    localparam logic [MUL_LAT-1:0] TOK_LAST = MUL_LAT'(1) << (MUL_LAT - 1);

`ifdef FIR_SEQ_ROUND_SAT_EN
    localparam logic signed [ACC_W:0] RND    = (ACC_W+1)'(1) << (COEF_W - 2);
    localparam logic signed [ACC_W:0] SAT_HI = ((ACC_W+1)'(1) << (DATA_W - 1)) - (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0] SAT_LO = -SAT_HI - (ACC_W+1)'(1);
`endif

    function automatic logic signed [DATA_W-1:0] scale(input logic signed [ACC_W-1:0] a);
`ifdef FIR_SEQ_ROUND_SAT_EN
        logic signed [ACC_W:0] r;
        logic signed [DATA_W-1:0] y;
        r = ((ACC_W+1)'(a) + RND) >>> (COEF_W - 1);
        if (r > SAT_HI)      y = DATA_W'(SAT_HI);
        else if (r < SAT_LO) y = DATA_W'(SAT_LO);
        else                 y = DATA_W'(r);
        return y;
`else
        return DATA_W'(a >>> (COEF_W - 1));
`endif
    endfunction

    state_e                   state_q, state_nxt;
    logic [AW-1:0]            k_q;
    logic [MUL_LAT-1:0]       tok_q;
    logic signed [ACC_W-1:0]  acc_q, acc_sum;
    logic signed [DATA_W-1:0] x_q [NTAPS];
    logic signed [COEF_W-1:0] c_q [NTAPS];
    logic signed [PW-1:0]     prod;
    logic                     accept, issue, load_out, coef_ok;
    logic                     s_ready_q, m_valid_q, busy_q, coef_drop_q;
    logic signed [DATA_W-1:0] m_data_q;

    fir_seq_mul_pipe #(
        .DATA_W  (DATA_W),
        .COEF_W  (COEF_W),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .ce    (1'b1),
        .a     (x_q[k_q]),
        .b     (c_q[k_q]),
        .p     (prod)
    );

    assign acc_sum = acc_q + ACC_W'(prod);
    assign coef_ok = bus.coef_we && (state_q == IDLE) && (32'(bus.coef_addr) < NTAPS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    // Leave DRAIN on the cycle the last in-flight token is accumulated.
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        issue     = 1'b0;
        load_out  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.s_valid && s_ready_q) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (k_q == AW'(NTAPS - 1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (tok_q == TOK_LAST) begin
                    load_out  = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (bus.m_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NTAPS); i++) begin
                x_q[i] <= '0;
                c_q[i] <= '0;
            end
            k_q   <= '0;
            tok_q <= '0;
            acc_q <= '0;
        end else begin
            if (accept) begin
                x_q[0] <= bus.s_data;
                for (int i = 1; i < int'(NTAPS); i++) x_q[i] <= x_q[i-1];
            end
            if (coef_ok) c_q[bus.coef_addr] <= bus.coef_wdata;
            if (accept)     k_q <= '0;
            else if (issue) k_q <= k_q + AW'(1);
            tok_q <= MUL_LAT'({tok_q, issue});
            if (accept)                   acc_q <= '0;
            else if (tok_q[MUL_LAT-1])    acc_q <= acc_sum;
        end
    end

    // Status outputs mirror the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            coef_drop_q <= 1'b0;
            m_data_q    <= '0;
        end else begin
            s_ready_q   <= (state_nxt == IDLE);
            m_valid_q   <= (state_nxt == OUT);
            busy_q      <= (state_nxt != IDLE);
            coef_drop_q <= bus.coef_we && !coef_ok;
            if (load_out) m_data_q <= scale(acc_sum);
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.busy      = busy_q;
    assign bus.coef_drop = coef_drop_q;
    assign bus.m_data    = m_data_q;

endmodule
